// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-master (core / DMA) arbiter for a single-port data memory,
//            with AMO lock support and a bounded DMA starvation window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_req_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
    input  logic                    cpu_lock_i,
    output logic                    cpu_gnt_o,
    output logic                    cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
    input  logic                    dma_req_i,
    input  logic [DATA_WIDTH/8-1:0] dma_we_i,
    input  logic [ADDR_WIDTH-1:0]   dma_addr_i,
    input  logic [DATA_WIDTH-1:0]   dma_wdata_i,
    output logic                    dma_gnt_o,
    output logic                    dma_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dma_rdata_o,
    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    locked_o
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_starve_cnt;
    logic [CW-1:0]   w_starve_nxt;
    logic            r_rsp_valid;
    logic            r_rsp_owner;   // 0 = core, 1 = DMA
    logic            w_cpu_gnt;
    logic            w_dma_gnt;
    logic [BW-1:0]   w_mem_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ARB;
            r_starve_cnt <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_owner  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_rsp_valid  <= (w_cpu_gnt | w_dma_gnt) && (w_mem_we == '0);
            if (w_cpu_gnt | w_dma_gnt) begin
                r_rsp_owner <= w_dma_gnt;
            end
        end
    end

    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;

        case (r_state)
            ST_LOCK: begin
                w_cpu_gnt = cpu_req_i;
                if (!cpu_lock_i) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                if (dma_req_i && (!cpu_req_i || (r_starve_cnt == C_CNT_MAX))) begin
                    w_dma_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = cpu_req_i;
                end
                if (w_cpu_gnt && cpu_lock_i) begin
                    w_state_nxt = ST_LOCK;
                end
                // Count only core wins that leave the DMA waiting
                if (w_dma_gnt || !dma_req_i) begin
                    w_starve_nxt = '0;
                end else if (w_cpu_gnt && (r_starve_cnt != C_CNT_MAX)) begin
                    w_starve_nxt = r_starve_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_mem_we    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_cpu_gnt) begin
            w_mem_we    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (w_dma_gnt) begin
            w_mem_we    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end
    end

    assign cpu_gnt_o    = w_cpu_gnt;
    assign dma_gnt_o    = w_dma_gnt;
    assign mem_en_o     = w_cpu_gnt | w_dma_gnt;
    assign mem_we_o     = w_mem_we;
    assign cpu_rvalid_o = r_rsp_valid && !r_rsp_owner;
    assign dma_rvalid_o = r_rsp_valid &&  r_rsp_owner;
    assign cpu_rdata_o  = mem_rdata_i;
    assign dma_rdata_o  = mem_rdata_i;
    assign locked_o     = (r_state == ST_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a behavioural memory and
//            arbitration reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req_i, cpu_lock_i, dma_req_i;
    logic [BW-1:0] cpu_we_i, dma_we_i;
    logic [AW-1:0] cpu_addr_i, dma_addr_i;
    logic [DW-1:0] cpu_wdata_i, dma_wdata_i;
    logic          cpu_gnt_o, cpu_rvalid_o, dma_gnt_o, dma_rvalid_o;
    logic [DW-1:0] cpu_rdata_o, dma_rdata_o;
    logic          mem_en_o, locked_o;
    logic [BW-1:0] mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_lock_i(cpu_lock_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o),
        .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .locked_o(locked_o)
    );

    // Environment memory: single port, one-cycle read latency
    logic [DW-1:0] env_mem [0:255];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o != '0) begin
                for (int b = 0; b < BW; b++)
                    if (mem_we_o[b]) env_mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= env_mem[mem_addr_o[9:2]];
            end
        end
    end

    typedef struct {
        bit            owner;   // 1 = DMA
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    bit            m_locked = 0;
    int            m_wait   = 0;
    logic [DW-1:0] ref_mem [0:255];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive, compare combinational outputs, advance the model
    task automatic step(input bit creq, input logic [BW-1:0] cwe, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] cwd, input bit clock,
                        input bit dreq, input logic [BW-1:0] dwe, input logic [AW-1:0] daddr,
                        input logic [DW-1:0] dwd, output bit cg, output bit dg);
        logic [BW-1:0] ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        @(posedge clk);
        cyc++;
        #3;
        cpu_req_i = creq; cpu_we_i = cwe; cpu_addr_i = caddr; cpu_wdata_i = cwd;
        cpu_lock_i = clock;
        dma_req_i = dreq; dma_we_i = dwe; dma_addr_i = daddr; dma_wdata_i = dwd;
        #4;
        cg = 0; dg = 0;
        if (m_locked) cg = creq;
        else if (dreq && (!creq || m_wait >= LIMIT)) dg = 1;
        else cg = creq;
        ewe = '0; eaddr = '0; ewd = '0;
        if (cg) begin ewe = cwe; eaddr = caddr; ewd = cwd; end
        else if (dg) begin ewe = dwe; eaddr = daddr; ewd = dwd; end
        chk("grant", {cpu_gnt_o, dma_gnt_o}, {cg, dg});
        chk("mem_drive", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, {cg | dg, ewe, eaddr, ewd});
        chk("locked", locked_o, m_locked);
        if ((cg || dg) && ewe == '0) begin
            sb.push_back('{dg, ref_mem[eaddr[9:2]], cyc + 1});
        end else if (cg || dg) begin
            for (int b = 0; b < BW; b++)
                if (ewe[b]) ref_mem[eaddr[9:2]][8*b +: 8] = ewd[8*b +: 8];
        end
        if (m_locked) begin
            m_locked = clock;
        end else begin
            if (dg || !dreq) m_wait = 0;
            else if (cg && m_wait < LIMIT) m_wait++;
            m_locked = cg && clock;
        end
    endtask

    task automatic idle();
        bit cg, dg;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    endtask

    task automatic do_reset();
        @(posedge clk);
        cyc++;
        #3;
        cpu_req_i = 0; dma_req_i = 0; cpu_lock_i = 0;
        reset_n = 0;
        #1;
        chk("rst_locked", locked_o, 1'b0);
        chk("rst_rvalid", {cpu_rvalid_o, dma_rvalid_o}, 2'b00);
        sb.delete();
        m_locked = 0;
        m_wait   = 0;
        #10;
        reset_n = 1;
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (reset_n) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    checks++; failures++;
                    $display("FAIL rsp_missing actual=none required=owner%0d/%0h due %0d", e.owner, e.data, e.due);
                end
                if (cpu_rvalid_o && dma_rvalid_o) begin
                    chk("rsp_both_valid", 2'b11, 2'b01);
                end else if (cpu_rvalid_o || dma_rvalid_o) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected actual=owner%0d required=none (cycle %0d)", dma_rvalid_o, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_owner", dma_rvalid_o, e.owner);
                        chk("rsp_time", cyc, e.due);
                        chk("rsp_data", dma_rvalid_o ? dma_rdata_o : cpu_rdata_o, e.data);
                    end
                end
            end
        end
    end

    initial begin
        bit cg, dg, cp, dp;
        bit creq, dreq, clock;
        logic [BW-1:0] cwe, dwe;
        logic [AW-1:0] caddr, daddr;
        logic [DW-1:0] cwd, dwd;
        int nc, ndg, lock_run;

        for (int i = 0; i < 256; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
        reset_n = 0;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0; cpu_lock_i = 0;
        dma_req_i = 0; dma_we_i = 0; dma_addr_i = 0; dma_wdata_i = 0;
        #1;
        chk("init_locked", locked_o, 1'b0);
        chk("init_rvalid", {cpu_rvalid_o, dma_rvalid_o}, 2'b00);
        chk("init_no_gnt", {cpu_gnt_o, dma_gnt_o, mem_en_o}, 3'b000);
        #21;
        reset_n = 1;

        // Simultaneous reads, fresh counter: core wins
        step(0, 0, 0, 0, 0, 1, 4'hF, 32'h100, 32'h1111_2222, cg, dg);
        step(0, 0, 0, 0, 0, 1, 4'hF, 32'h200, 32'h3333_4444, cg, dg);
        step(1, 0, 32'h100, 0, 0, 1, 0, 32'h200, 0, cg, dg);
        chk("t1_cpu_wins", {cg, dg}, 2'b10);
        step(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, cg, dg);
        idle();

        // DMA write with core idle, then core reads it back
        step(0, 0, 0, 0, 0, 1, 4'hF, 32'h80, 32'hDEAD_BEEF, cg, dg);
        chk("t4_dma_write_gnt", dg, 1'b1);
        step(1, 0, 32'h80, 0, 0, 0, 0, 0, 0, cg, dg);
        idle();
        chk("t4_mem_content", ref_mem[8'h20], 32'hDEAD_BEEF);

        // Starvation bound
        nc = 0; dg = 0;
        for (int i = 0; i < 20 && !dg; i++) begin
            step(1, 0, 32'h10 + 4 * i, 0, 0, 1, 0, 32'h300, 0, cg, dg);
            if (cg) nc++;
        end
        chk("t3_cpu_grants_before_dma", nc, LIMIT);
        chk("t3_dma_granted", dg, 1'b1);
        step(1, 0, 32'h14, 0, 0, 1, 0, 32'h304, 0, cg, dg);
        chk("t3_cnt_cleared", {cg, dg}, 2'b10);
        step(0, 0, 0, 0, 0, 1, 0, 32'h304, 0, cg, dg);

        // Locked read-modify-write with DMA pending throughout
        ndg = 0;
        step(1, 0, 32'h40, 0, 1, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg); ndg += dg;
        step(0, 0, 0, 0, 1, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg);     ndg += dg;
        step(0, 0, 0, 0, 1, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg);     ndg += dg;
        step(1, 4'hF, 32'h40, 32'h0000_0042, 1, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg); ndg += dg;
        chk("t2_locked_state", locked_o, 1'b1);
        step(0, 0, 0, 0, 0, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg);     ndg += dg;
        chk("t2_no_dma_during_lock", ndg, 0);
        step(0, 0, 0, 0, 0, 1, 4'hF, 32'h40, 32'hBAD0_BAD0, cg, dg);
        chk("t2_dma_after_unlock", dg, 1'b1);
        step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, cg, dg);

        // Alternating single-master reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 0, 32'h80 + 4 * i, 0, 0, 0, 0, 0, 0, cg, dg);
            else            step(0, 0, 0, 0, 0, 1, 0, 32'h100 - 4 * i, 0, cg, dg);
        end
        idle();

        // Reset while locked with a read response outstanding
        step(1, 0, 32'h80, 0, 1, 0, 0, 0, 0, cg, dg);
        do_reset();
        step(1, 0, 32'h84, 0, 0, 1, 0, 32'h100, 0, cg, dg);
        chk("t6_post_reset_arb", {cg, dg}, 2'b10);
        step(0, 0, 0, 0, 0, 1, 0, 32'h100, 0, cg, dg);
        chk("t6_dma_granted", dg, 1'b1);
        idle();

        // Randomized traffic honouring hold-until-grant
        cp = 0; dp = 0; lock_run = 0;
        creq = 0; dreq = 0; cwe = 0; dwe = 0; caddr = 0; daddr = 0; cwd = 0; dwd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!cp) begin
                creq  = ($urandom % 4) != 0;
                cwe   = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
                caddr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
                cwd   = $urandom;
            end
            if (!dp) begin
                dreq  = ($urandom % 3) != 0;
                dwe   = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
                daddr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
                dwd   = $urandom;
            end
            if (lock_run == 0 && ($urandom % 12) == 0) lock_run = $urandom_range(1, 6);
            clock = lock_run > 0;
            if (lock_run > 0) lock_run--;
            step(creq, cwe, caddr, cwd, clock, dreq, dwe, daddr, dwd, cg, dg);
            cp = creq && !cg;
            dp = dreq && !dg;
            if (i == 1500) begin
                do_reset();
                cp = 0; dp = 0; lock_run = 0;
            end
        end

        for (int i = 0; i < 4; i++) idle();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
